dmem_port_ctrl: RTL and testbench

//  Data-memory access sequencer between the core load/store unit and the big-endian

---
 rtl/dmem_port_ctrl_pkg.sv | 31 +++
 rtl/dmem_port_ctrl_lane_mux.sv | 63 ++++++
 rtl/dmem_port_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_dmem_port_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_ctrl_pkg.sv
// Shared definitions for the data-memory port controller.
//   dmem_state_e : sequencer states
//   dmem_size_e  : request size encoding (byte / 16-bit word)
//   CNT_W        : width of the RAM read-latency counter (covers RD_LAT up to 4)
//   next_word    : RAM word address of the following word, wrapping 0x1FF -> 0x000
package dmem_port_ctrl_pkg;

    // ST_ERR is the cycle-0 state of a rejected request; ST_RESP is the state
    // during which the registered response pulse is visible.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_A,
        ST_WR_B,
        ST_RD_A,
        ST_RD_B,
        ST_ERR,
        ST_RESP
    } dmem_state_e;

    typedef enum logic {
        SZ_BYTE = 1'b0,
        SZ_WORD = 1'b1
    } dmem_size_e;

    localparam int unsigned CNT_W = 3;

    function automatic logic [8:0] next_word(input logic [8:0] word_addr);
        return word_addr + 9'd1;
    endfunction

endpackage

// File: rtl/dmem_port_ctrl_lane_mux.sv
// Combinational byte-lane steering for the big-endian data RAM.
//   i_size    : 0 byte, 1 word
//   i_a0      : byte address bit 0 (0 -> high lane, 1 -> low lane)
//   i_part_b  : second access of a misaligned word
//   i_sext    : sign-extend byte loads
//   i_wdata   : store data
//   i_dout_h/l: RAM read data lanes
//   i_cap_l   : low-lane byte captured from part A of a misaligned load
//   o_we_h/l  : lane write strobes (qualified by the caller with store/enable)
//   o_din_h/l : lane write data
//   o_rdata   : assembled / extended load result
module dmem_lane_mux
    import dmem_port_ctrl_pkg::*;
(
    input  logic        i_size,
    input  logic        i_a0,
    input  logic        i_part_b,
    input  logic        i_sext,
    input  logic [15:0] i_wdata,
    input  logic [7:0]  i_dout_h,
    input  logic [7:0]  i_dout_l,
    input  logic [7:0]  i_cap_l,
    output logic        o_we_h,
    output logic        o_we_l,
    output logic [7:0]  o_din_h,
    output logic [7:0]  o_din_l,
    output logic [15:0] o_rdata
);

    logic [7:0] lane_b;

    always_comb begin
        o_we_h  = 1'b0;
        o_we_l  = 1'b0;
        o_din_h = i_wdata[7:0];
        o_din_l = i_wdata[7:0];
        o_rdata = '0;
        lane_b  = '0;
        if (i_size == SZ_BYTE) begin
            o_we_h  = ~i_a0;
            o_we_l  = i_a0;
            lane_b  = i_a0 ? i_dout_l : i_dout_h;
            o_rdata = i_sext ? {{8{lane_b[7]}}, lane_b} : {8'h00, lane_b};
        end else if (!i_a0) begin
            o_we_h  = 1'b1;
            o_we_l  = 1'b1;
            o_din_h = i_wdata[15:8];
            o_rdata = {i_dout_h, i_dout_l};
        end else begin
            // Misaligned word: part A carries the MSB into the low lane of the
            // addressed word, part B the LSB into the high lane of the next word.
            if (i_part_b) begin
                o_we_h = 1'b1;
            end else begin
                o_we_l  = 1'b1;
                o_din_h = i_wdata[15:8];
                o_din_l = i_wdata[15:8];
            end
            o_rdata = {i_cap_l, i_dout_h};
        end
    end

endmodule

// File: rtl/dmem_port_ctrl.sv
// Data-memory access sequencer between the load/store unit and the big-endian
// byte-lane data RAM.
//   Request : i_req_valid/o_req_ready handshake, i_req_we, i_req_size,
//             i_req_sext, i_req_addr (byte), i_req_wdata
//   Response: o_rsp_valid one-cycle pulse, o_rsp_rdata (held), o_rsp_err
//   RAM     : o_mem_en, o_mem_we_h/l, o_mem_addr (word), o_mem_din_h/l,
//             i_mem_dout_h/l valid RD_LAT edges after the address is presented
// Parameters: RD_LAT (1..4), ALLOW_MISALIGN (1 split odd words, 0 reject).
module dmem_port_ctrl
    import dmem_port_ctrl_pkg::*;
#(
    parameter int unsigned RD_LAT         = 2,
    parameter bit          ALLOW_MISALIGN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic        i_req_size,
    input  logic        i_req_sext,
    input  logic [9:0]  i_req_addr,
    input  logic [15:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [15:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_mem_en,
    output logic        o_mem_we_h,
    output logic        o_mem_we_l,
    output logic [8:0]  o_mem_addr,
    output logic [7:0]  o_mem_din_h,
    output logic [7:0]  o_mem_din_l,
    input  logic [7:0]  i_mem_dout_h,
    input  logic [7:0]  i_mem_dout_l
);

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(RD_LAT);

    dmem_state_e      state_q, state_d;
    logic             rdy_q, rdy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic             size_q, size_d;
    logic             sext_q, sext_d;
    logic [9:0]       addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [7:0]       cap_q, cap_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_we_h_q, mem_we_h_d;
    logic             mem_we_l_q, mem_we_l_d;
    logic [8:0]       mem_addr_q, mem_addr_d;
    logic [7:0]       mem_din_h_q, mem_din_h_d;
    logic [7:0]       mem_din_l_q, mem_din_l_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [15:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;

    logic        accept;
    logic        misal_in;
    logic        split;
    logic        lm_size, lm_a0, lm_part_b;
    logic [15:0] lm_wdata;
    logic        lm_we_h, lm_we_l;
    logic [7:0]  lm_din_h, lm_din_l;
    logic [15:0] lm_rdata;

    assign o_req_ready = rdy_q & ~i_rst;
    assign accept      = i_req_valid & o_req_ready;
    assign misal_in    = i_req_size & i_req_addr[0];
    assign split       = size_q & addr_q[0];

    // The first access is steered from the live request, later parts from the latch.
    always_comb begin
        lm_size   = accept ? i_req_size     : size_q;
        lm_a0     = accept ? i_req_addr[0]  : addr_q[0];
        lm_wdata  = accept ? i_req_wdata    : wdata_q;
        lm_part_b = (state_q == ST_WR_A);
    end

    dmem_lane_mux u_lane_mux (
        .i_size   (lm_size),
        .i_a0     (lm_a0),
        .i_part_b (lm_part_b),
        .i_sext   (sext_q),
        .i_wdata  (lm_wdata),
        .i_dout_h (i_mem_dout_h),
        .i_dout_l (i_mem_dout_l),
        .i_cap_l  (cap_q),
        .o_we_h   (lm_we_h),
        .o_we_l   (lm_we_l),
        .o_din_h  (lm_din_h),
        .o_din_l  (lm_din_l),
        .o_rdata  (lm_rdata)
    );

    always_comb begin
        state_d     = state_q;
        rdy_d       = 1'b0;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        sext_d      = sext_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cap_d       = cap_q;
        mem_en_d    = 1'b0;
        mem_we_h_d  = 1'b0;
        mem_we_l_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_h_d = mem_din_h_q;
        mem_din_l_d = mem_din_l_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                rdy_d   = 1'b1;
                if (accept) begin
                    rdy_d   = 1'b0;
                    cnt_d   = '0;
                    we_d    = i_req_we;
                    size_d  = i_req_size;
                    sext_d  = i_req_sext;
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
                    if (misal_in && !ALLOW_MISALIGN) begin
                        state_d = ST_ERR;
                    end else begin
                        mem_en_d   = 1'b1;
                        mem_addr_d = i_req_addr[9:1];
                        if (i_req_we) begin
                            mem_we_h_d  = lm_we_h;
                            mem_we_l_d  = lm_we_l;
                            mem_din_h_d = lm_din_h;
                            mem_din_l_d = lm_din_l;
                            state_d     = ST_WR_A;
                        end else begin
                            state_d = ST_RD_A;
                        end
                    end
                end
            end
            ST_WR_A: begin
                if (split) begin
                    mem_en_d    = 1'b1;
                    mem_we_h_d  = lm_we_h;
                    mem_we_l_d  = lm_we_l;
                    mem_din_h_d = lm_din_h;
                    mem_din_l_d = lm_din_l;
                    mem_addr_d  = next_word(addr_q[9:1]);
                    state_d     = ST_WR_B;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rdy_d       = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_WR_B: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                rdy_d       = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RD_A, ST_RD_B: begin
                if (cnt_q != LAT_CNT) begin
                    mem_en_d = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end else if (state_q == ST_RD_A && split) begin
                    // Capture part A and launch part B on the same edge.
                    cap_d      = i_mem_dout_l;
                    mem_en_d   = 1'b1;
                    mem_addr_d = next_word(addr_q[9:1]);
                    cnt_d      = '0;
                    state_d    = ST_RD_B;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = lm_rdata;
                    rdy_d       = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_ERR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_rdata_d = '0;
                rdy_d       = 1'b1;
                state_d     = ST_RESP;
            end
            default: begin
                state_d = ST_IDLE;
                rdy_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            rdy_q       <= 1'b1;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= 1'b0;
            sext_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cap_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_h_q  <= 1'b0;
            mem_we_l_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_h_q <= '0;
            mem_din_l_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cap_q       <= cap_d;
            mem_en_q    <= mem_en_d;
            mem_we_h_q  <= mem_we_h_d;
            mem_we_l_q  <= mem_we_l_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_h_q <= mem_din_h_d;
            mem_din_l_q <= mem_din_l_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // The latched store flag is only informative; stores and loads are told
    // apart by the state they entered.
    logic unused_we;
    assign unused_we = we_q;

    assign o_mem_en    = mem_en_q;
    assign o_mem_we_h  = mem_we_h_q;
    assign o_mem_we_l  = mem_we_l_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_din_h = mem_din_h_q;
    assign o_mem_din_l = mem_din_l_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Bench for dmem_port_ctrl: a latency-accurate RAM emulator behind the main
// instance, a byte-array reference model of memory contents, and a second
// instance with misaligned words rejected.
module tb_dmem_port_ctrl;

    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_we = 1'b0, req_size = 1'b0, req_sext = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, mem_en, we_h, we_l;
    logic [15:0] rsp_rdata;
    logic [8:0]  mem_addr;
    logic [7:0]  din_h, din_l, dout_h, dout_l;

    logic        nm_valid = 1'b0, nm_we = 1'b0, nm_size = 1'b0, nm_sext = 1'b0;
    logic [9:0]  nm_addr = '0;
    logic [15:0] nm_wdata = '0;
    logic        nm_ready, nm_rsp_valid, nm_rsp_err, nm_mem_en, nm_we_h, nm_we_l;
    logic [15:0] nm_rdata;
    logic [8:0]  nm_mem_addr;
    logic [7:0]  nm_din_h, nm_din_l;

    dmem_port_ctrl #(.RD_LAT(RD_LAT), .ALLOW_MISALIGN(1'b1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_we(req_we), .i_req_size(req_size), .i_req_sext(req_sext),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_mem_en(mem_en), .o_mem_we_h(we_h), .o_mem_we_l(we_l),
        .o_mem_addr(mem_addr), .o_mem_din_h(din_h), .o_mem_din_l(din_l),
        .i_mem_dout_h(dout_h), .i_mem_dout_l(dout_l)
    );

    dmem_port_ctrl #(.RD_LAT(RD_LAT), .ALLOW_MISALIGN(1'b0)) dut_nm (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(nm_valid), .o_req_ready(nm_ready),
        .i_req_we(nm_we), .i_req_size(nm_size), .i_req_sext(nm_sext),
        .i_req_addr(nm_addr), .i_req_wdata(nm_wdata),
        .o_rsp_valid(nm_rsp_valid), .o_rsp_rdata(nm_rdata), .o_rsp_err(nm_rsp_err),
        .o_mem_en(nm_mem_en), .o_mem_we_h(nm_we_h), .o_mem_we_l(nm_we_l),
        .o_mem_addr(nm_mem_addr), .o_mem_din_h(nm_din_h), .o_mem_din_l(nm_din_l),
        .i_mem_dout_h(8'h5A), .i_mem_dout_l(8'hC3)
    );

    // RAM emulator: read-before-write, data RD_LAT edges after address sampling.
    logic [7:0] ram_h [512];
    logic [7:0] ram_l [512];
    logic [7:0] pipe_h [RD_LAT];
    logic [7:0] pipe_l [RD_LAT];
    bit         filled = 1'b0;

    always @(posedge clk) begin
        if (!filled) begin
            for (int w = 0; w < 512; w++) begin
                ram_h[w] = 8'($urandom);
                ram_l[w] = 8'($urandom);
            end
            filled = 1'b1;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipe_h[i] <= pipe_h[i-1];
                pipe_l[i] <= pipe_l[i-1];
            end
            pipe_h[0] <= ram_h[mem_addr];
            pipe_l[0] <= ram_l[mem_addr];
            if (mem_en && we_h) ram_h[mem_addr] = din_h;
            if (mem_en && we_l) ram_l[mem_addr] = din_l;
        end
    end
    assign dout_h = pipe_h[RD_LAT-1];
    assign dout_l = pipe_l[RD_LAT-1];

    // Reference model: flat big-endian byte memory.
    logic [7:0] mdl [1024];
    int n_vec = 0;
    int n_err = 0;
    logic [15:0] last_rdata = '0;

    function automatic logic [15:0] ref_load(input logic size, input logic sext, input logic [9:0] a);
        logic [7:0] b;
        logic [9:0] a1;
        a1 = a + 10'd1;
        if (!size) begin
            b = mdl[a];
            return sext ? {{8{b[7]}}, b} : {8'h00, b};
        end
        return {mdl[a], mdl[a1]};
    endfunction

    task automatic ref_store(input logic size, input logic [9:0] a, input logic [15:0] wd);
        logic [9:0] a1;
        a1 = a + 10'd1;
        if (!size) begin
            mdl[a] = wd[7:0];
        end else begin
            mdl[a]  = wd[15:8];
            mdl[a1] = wd[7:0];
        end
    endtask

    task automatic issue(input logic we, input logic size, input logic sext,
                         input logic [9:0] a, input logic [15:0] wd);
        req_valid = 1'b1; req_we = we; req_size = size; req_sext = sext;
        req_addr = a; req_wdata = wd;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_at_issue: got %b want 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_size = 1'($urandom); req_sext = 1'($urandom);
        req_addr = 10'($urandom); req_wdata = 16'($urandom);
    endtask

    // Returns at the negedge inside the response-pulse cycle.
    task automatic expect_rsp(input string nm, input logic [15:0] exp, input int lat,
                              input int ewh, input int ewl,
                              output logic [8:0] fa, output logic [8:0] la);
        int nwh = 0;
        int nwl = 0;
        bit got = 1'b0;
        fa = '0;
        la = '0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (mem_en && (we_h || we_l)) begin
                if (nwh + nwl == 0) fa = mem_addr;
                la = mem_addr;
            end
            if (mem_en && we_h) nwh++;
            if (mem_en && we_l) nwl++;
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                n_vec++;
                if (n != lat) begin n_err++; $display("FAIL %s latency: got %0d want %0d", nm, n, lat); end
                n_vec++;
                if (rsp_rdata !== exp) begin n_err++; $display("FAIL %s rdata: got %h want %h", nm, rsp_rdata, exp); end
                n_vec++;
                if (rsp_err !== 1'b0) begin n_err++; $display("FAIL %s err: got %b want 0", nm, rsp_err); end
                n_vec++;
                if (nwh != ewh || nwl != ewl) begin
                    n_err++;
                    $display("FAIL %s strobes: got h=%0d l=%0d want h=%0d l=%0d", nm, nwh, nwl, ewh, ewl);
                end
                n_vec++;
                if (mem_en !== 1'b0) begin n_err++; $display("FAIL %s en_in_pulse: got %b want 0", nm, mem_en); end
                last_rdata = rsp_rdata;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: got no response want one within 40 cycles", nm);
        end
    endtask

    task automatic run_txn(input string nm, input logic we, input logic size, input logic sext,
                           input logic [9:0] a, input logic [15:0] wd,
                           output logic [8:0] fa, output logic [8:0] la);
        logic [15:0] exp;
        int lat;
        int ewh;
        int ewl;
        bit splt;
        splt = size && a[0];
        exp = we ? 16'h0000 : ref_load(size, sext, a);
        if (we) lat = splt ? 2 : 1;
        else    lat = splt ? 2 * (RD_LAT + 1) : RD_LAT + 1;
        ewh = (we && (size || !a[0])) ? 1 : 0;
        ewl = (we && (size || a[0]))  ? 1 : 0;
        issue(we, size, sext, a, wd);
        expect_rsp(nm, exp, lat, ewh, ewl, fa, la);
        if (we) ref_store(size, a, wd);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || mem_en !== 1'b0 || we_h !== 1'b0 ||
            we_l !== 1'b0 || rsp_rdata !== 16'h0 || rsp_err !== 1'b0 || mem_addr !== 9'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b v=%b en=%b we=%b%b rd=%h err=%b addr=%h want all 0",
                     req_ready, rsp_valid, mem_en, we_h, we_l, rsp_rdata, rsp_err, mem_addr);
        end
        for (int w = 0; w < 512; w++) begin
            mdl[2*w]   = ram_h[w];
            mdl[2*w+1] = ram_l[w];
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_en !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: got rdy=%b v=%b en=%b want 1 0 0", req_ready, rsp_valid, mem_en);
        end
    endtask

    task automatic test_aligned_word();
        logic [8:0] fa, la;
        run_txn("st_word_100", 1'b1, 1'b1, 1'b0, 10'h100, 16'hABCD, fa, la);
        n_vec++;
        if (fa !== 9'h080) begin n_err++; $display("FAIL st_word_addr: got %h want 080", fa); end
        @(negedge clk);
        run_txn("ld_word_100", 1'b0, 1'b1, 1'b0, 10'h100, 16'h0000, fa, la);
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== last_rdata) begin
            n_err++;
            $display("FAIL rdata_hold: got v=%b rd=%h want v=0 rd=%h", rsp_valid, rsp_rdata, last_rdata);
        end
    endtask

    task automatic test_byte();
        logic [8:0] fa, la;
        run_txn("st_byte_101", 1'b1, 1'b0, 1'b0, 10'h101, 16'h7785, fa, la);
        @(negedge clk);
        run_txn("ld_byte_sext", 1'b0, 1'b0, 1'b1, 10'h101, 16'h0, fa, la);
        @(negedge clk);
        run_txn("ld_byte_zext", 1'b0, 1'b0, 1'b0, 10'h101, 16'h0, fa, la);
        @(negedge clk);
        run_txn("ld_byte_100", 1'b0, 1'b0, 1'b0, 10'h100, 16'h0, fa, la);
    endtask

    task automatic test_misaligned();
        logic [8:0] fa, la;
        @(negedge clk);
        run_txn("st_mis_3ff", 1'b1, 1'b1, 1'b0, 10'h3FF, 16'h1234, fa, la);
        n_vec++;
        if (fa !== 9'h1FF || la !== 9'h000) begin
            n_err++;
            $display("FAIL st_mis_addrs: got %h,%h want 1ff,000", fa, la);
        end
        @(negedge clk);
        run_txn("ld_mis_3ff", 1'b0, 1'b1, 1'b0, 10'h3FF, 16'h0, fa, la);
    endtask

    task automatic test_reject();
        bit touched = 1'b0;
        bit got = 1'b0;
        int at = -1;
        logic [15:0] rd = '0;
        logic er = 1'b0;
        @(negedge clk);
        nm_valid = 1'b1; nm_we = 1'b0; nm_size = 1'b1; nm_addr = 10'h011;
        n_vec++;
        if (nm_ready !== 1'b1) begin n_err++; $display("FAIL nm_ready: got %b want 1", nm_ready); end
        @(posedge clk);
        #1;
        nm_valid = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (nm_mem_en || nm_we_h || nm_we_l || nm_mem_addr != 9'h0 || nm_din_h != 8'h0 || nm_din_l != 8'h0)
                touched = 1'b1;
            if (nm_rsp_valid === 1'b1 && !got) begin got = 1'b1; at = n; rd = nm_rdata; er = nm_rsp_err; end
        end
        n_vec++;
        if (at != 1 || er !== 1'b1 || rd !== 16'h0) begin
            n_err++;
            $display("FAIL reject_rsp: got cycle=%0d err=%b rd=%h want 1 1 0000", at, er, rd);
        end
        n_vec++;
        if (touched) begin n_err++; $display("FAIL reject_no_ram: got ram activity want none"); end
        nm_valid = 1'b1; nm_size = 1'b1; nm_addr = 10'h010;
        @(posedge clk);
        #1;
        nm_valid = 1'b0;
        got = 1'b0;
        at = -1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (nm_rsp_valid === 1'b1 && !got) begin got = 1'b1; at = n; rd = nm_rdata; er = nm_rsp_err; end
        end
        n_vec++;
        if (at != RD_LAT + 1 || er !== 1'b0 || rd !== 16'h5AC3) begin
            n_err++;
            $display("FAIL nm_aligned_load: got cycle=%0d err=%b rd=%h want %0d 0 5ac3", at, er, rd, RD_LAT + 1);
        end
    endtask

    task automatic test_reset_midload();
        bit seen = 1'b0;
        logic [8:0] fa, la;
        @(negedge clk);
        issue(1'b0, 1'b1, 1'b0, 10'h100, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (mem_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midload_reset: got en=%b v=%b rdy=%b want 0 0 0", mem_en, rsp_valid, req_ready);
        end
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || mem_en !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin n_err++; $display("FAIL midload_dropped: got activity after reset want none"); end
        run_txn("ld_after_reset", 1'b0, 1'b1, 1'b0, 10'h100, 16'h0, fa, la);
    endtask

    task automatic test_back_to_back();
        logic [8:0] fa, la;
        @(negedge clk);
        run_txn("b2b_st", 1'b1, 1'b1, 1'b0, 10'h2A4, 16'hC0DE, fa, la);
        run_txn("b2b_ld", 1'b0, 1'b1, 1'b0, 10'h2A4, 16'h0, fa, la);
        run_txn("b2b_ldb", 1'b0, 1'b0, 1'b1, 10'h2A5, 16'h0, fa, la);
    endtask

    task automatic test_random();
        logic [9:0] pool [8];
        logic [9:0] a;
        logic [8:0] fa, la;
        pool = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h1FF, 10'h200, 10'h101, 10'h100};
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) a = pool[$urandom_range(0, 7)];
            else                           a = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 2) != 0) @(negedge clk);
            run_txn("random", 1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom), fa, la);
        end
    endtask

    task automatic test_mem_image();
        int diffs = 0;
        @(negedge clk);
        for (int w = 0; w < 512; w++) begin
            if (ram_h[w] !== mdl[2*w] || ram_l[w] !== mdl[2*w+1]) diffs++;
        end
        n_vec++;
        if (diffs != 0) begin n_err++; $display("FAIL mem_image: got %0d differing words want 0", diffs); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_aligned_word();
        test_byte();
        test_misaligned();
        test_reject();
        test_reset_midload();
        test_back_to_back();
        test_random();
        test_mem_image();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
